ras_ctrl: RTL and testbench

Return-address-stack controller: the initiator side of the depth-limited return address stack.
- Classifies fetched RISC-V jumps as call, return or coroutine swap.
- Issues push/pop to the stack and returns a predicted return target to fetch.
- Owns stack recovery: on a pipeline flush, drains the stack to empty with one pop per cycle, since the stack has no clear input other than reset.

---
 rtl/ras_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ras_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - return-address-stack controller: jump classification, stack strobes, return prediction, flush drain
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   inst_valid/ready    fetch handshake; ready only while running
//   inst_pc, inst       PC and word of the presented instruction
//   flush               backend redirect; empties the stack by draining
//   pred_valid/hit      one-cycle prediction pulse for returns and swaps
//   pred_target         predicted return address (held between pulses)
//   stk_push/pop        stack strobes; stk_push_data is the call PC+4
//   stk_pop_data        current stack top
//   stk_full/empty      stack occupancy flags

module ras_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [XLEN-1:0] inst_pc,
    input  logic [31:0]     inst,
    input  logic            flush,
    output logic            pred_valid,
    output logic            pred_hit,
    output logic [XLEN-1:0] pred_target,
    output logic            stk_push,
    output logic            stk_pop,
    output logic [XLEN-1:0] stk_push_data,
    input  logic [XLEN-1:0] stk_pop_data,
    input  logic            stk_full,
    input  logic            stk_empty
);

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic              s_valid_q, s_valid_d;
    logic [31:0]       s_inst_q, s_inst_d;
    logic [XLEN-1:0]   s_pc_q, s_pc_d;
    logic              pv_q, pv_d;
    logic              hit_q, hit_d;
    logic [XLEN-1:0]   tgt_q, tgt_d;

    // Decode of the stage register
    logic [6:0] opcode;
    logic [4:0] rd, rs1;
    logic [2:0] funct3;
    logic       is_jal, is_jalr, link_rd, link_rs1;
    logic       is_call, is_ret, is_swap;
    logic       unused_inst_bits;

    assign opcode   = s_inst_q[6:0];
    assign rd       = s_inst_q[11:7];
    assign funct3   = s_inst_q[14:12];
    assign rs1      = s_inst_q[19:15];
    // Immediate bits play no part in classification.
    assign unused_inst_bits = ^s_inst_q[31:20];

    assign is_jal   = (opcode == 7'b1101111);
    assign is_jalr  = (opcode == 7'b1100111) && (funct3 == 3'b000);
    assign link_rd  = (rd == 5'd1) || (rd == 5'd5);
    assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);

    // rd==rs1 with a link register is a plain call, not a coroutine swap.
    assign is_call  = (is_jal && link_rd) ||
                      (is_jalr && link_rd && (!link_rs1 || (rd == rs1)));
    assign is_ret   = is_jalr && link_rs1 && !link_rd;
    assign is_swap  = is_jalr && link_rd && link_rs1 && (rd != rs1);

    always_comb begin
        state_d       = state_q;
        s_valid_d     = 1'b0;
        s_inst_d      = s_inst_q;
        s_pc_d        = s_pc_q;
        pv_d          = 1'b0;
        hit_d         = 1'b0;
        tgt_d         = tgt_q;
        inst_ready    = 1'b0;
        stk_push      = 1'b0;
        stk_pop       = 1'b0;
        stk_push_data = s_pc_q + XLEN'(4);

        case (state_q)
            ST_RUN: begin
                inst_ready = 1'b1;
                if (flush) begin
                    // Stage contents and any prediction from it are discarded.
                    state_d = ST_DRAIN;
                end else begin
                    if (inst_valid) begin
                        s_valid_d = 1'b1;
                        s_inst_d  = inst;
                        s_pc_d    = inst_pc;
                    end
                    if (s_valid_q) begin
                        if (is_call) begin
                            // Asserted even when full; the stack drops it.
                            stk_push = 1'b1;
                        end
                        if (is_ret) begin
                            stk_pop = !stk_empty;
                            pv_d    = 1'b1;
                            hit_d   = !stk_empty;
                        end
                        if (is_swap) begin
                            // Empty: push only. Full: pop only, new link lost.
                            stk_push = !stk_full;
                            stk_pop  = !stk_empty;
                            pv_d     = 1'b1;
                            hit_d    = !stk_empty;
                        end
                        if (pv_d) begin
                            tgt_d = hit_d ? stk_pop_data : '0;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                stk_pop = !stk_empty;
                if (stk_empty) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // No stack strobe may escape while reset is applied.
        if (rst) begin
            stk_push = 1'b0;
            stk_pop  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            s_valid_q <= 1'b0;
            s_inst_q  <= '0;
            s_pc_q    <= '0;
            pv_q      <= 1'b0;
            hit_q     <= 1'b0;
            tgt_q     <= '0;
        end else begin
            state_q   <= state_d;
            s_valid_q <= s_valid_d;
            s_inst_q  <= s_inst_d;
            s_pc_q    <= s_pc_d;
            pv_q      <= pv_d;
            hit_q     <= hit_d;
            tgt_q     <= tgt_d;
        end
    end

    assign pred_valid  = pv_q;
    assign pred_hit    = hit_q;
    assign pred_target = tgt_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// tb/tb_ras_ctrl.sv - self-checking bench for ras_ctrl with a 7-entry stack model

module tb_ras_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        flush;
    logic        pred_valid;
    logic        pred_hit;
    logic [31:0] pred_target;
    logic        stk_push;
    logic        stk_pop;
    logic [31:0] stk_push_data;
    logic [31:0] stk_pop_data;
    logic        stk_full;
    logic        stk_empty;

    always #5 clk = ~clk;

    ras_ctrl #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_pc       (inst_pc),
        .inst          (inst),
        .flush         (flush),
        .pred_valid    (pred_valid),
        .pred_hit      (pred_hit),
        .pred_target   (pred_target),
        .stk_push      (stk_push),
        .stk_pop       (stk_pop),
        .stk_push_data (stk_push_data),
        .stk_pop_data  (stk_pop_data),
        .stk_full      (stk_full),
        .stk_empty     (stk_empty)
    );

    // Stack model: 7 entries, push when full is dropped, push+pop replaces top.
    logic [31:0] mem [0:6];
    int          cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            cnt <= 0;
        end else if (stk_push && stk_pop && cnt > 0) begin
            mem[cnt-1] <= stk_push_data;
        end else if (stk_push && !stk_pop) begin
            if (cnt < 7) begin
                mem[cnt] <= stk_push_data;
                cnt      <= cnt + 1;
            end
        end else if (stk_pop && !stk_push && cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    assign stk_full     = (cnt == 7);
    assign stk_empty    = (cnt == 0);
    assign stk_pop_data = (cnt > 0) ? mem[(cnt > 0) ? cnt-1 : 0] : 32'hDEADBEEF;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        push;
        logic        pop;
        logic [31:0] data;
        logic        pv;
        logic        hit;
        logic [31:0] tgt;
    } vec_t;

    typedef struct {
        int          due;
        logic        push;
        logic        pop;
        logic [31:0] data;
        logic        pv;
        logic        hit;
        logic [31:0] tgt;
    } exp_t;

    vec_t vecs[$];
    exp_t sq[$];
    exp_t pq[$];

    function automatic logic [31:0] jal(input int rd);
        return {20'b0, 5'(rd), 7'b1101111};
    endfunction

    function automatic logic [31:0] jalr(input int rd, input int rs1, input int f3 = 0);
        return {12'b0, 5'(rs1), 3'(f3), 5'(rd), 7'b1100111};
    endfunction

    function automatic void add(input logic [31:0] pc, input logic [31:0] ins,
                                input logic push, input logic pop, input logic [31:0] data,
                                input logic pv, input logic hit, input logic [31:0] tgt);
        vec_t v;
        v.pc = pc; v.ins = ins; v.push = push; v.pop = pop; v.data = data;
        v.pv = pv; v.hit = hit; v.tgt = tgt;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and queue its expected stack and prediction responses.
    task automatic drive(input vec_t v);
        exp_t e;
        inst_valid = 1'b1;
        inst_pc    = v.pc;
        inst       = v.ins;
        e.push = v.push; e.pop = v.pop; e.data = v.data;
        e.pv = v.pv; e.hit = v.hit; e.tgt = v.tgt;
        e.due = cyc + 1;
        sq.push_back(e);
        e.due = cyc + 2;
        pq.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            exp_t e;
            e = sq.pop_front();
            chk("stk_push", {31'b0, stk_push}, {31'b0, e.push});
            chk("stk_pop", {31'b0, stk_pop}, {31'b0, e.pop});
            if (e.push) chk("stk_push_data", stk_push_data, e.data);
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            exp_t e;
            e = pq.pop_front();
            chk("pred_valid", {31'b0, pred_valid}, {31'b0, e.pv});
            chk("pred_hit", {31'b0, pred_hit}, {31'b0, e.hit});
            if (e.pv) chk("pred_target", pred_target, e.tgt);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   pops;
        bit   drained;

        // CALL then RET
        add(32'h1000, jal(1),     1, 0, 32'h1004, 0, 0, 0);
        add(32'h2000, jalr(0, 1), 0, 1, 0,        1, 1, 32'h1004);
        // RET on empty stack
        add(32'h3000, jalr(0, 1), 0, 0, 0,        1, 0, 0);
        // Eight nested calls, eighth dropped, then eight returns
        for (int k = 1; k <= 8; k++)
            add(32'(k * 32'h100), jal(1), 1, 0, 32'(k * 32'h100 + 4), 0, 0, 0);
        for (int k = 7; k >= 1; k--)
            add(32'h3100, jalr(0, 1), 0, 1, 0, 1, 1, 32'(k * 32'h100 + 4));
        add(32'h3200, jalr(0, 1), 0, 0, 0, 1, 0, 0);
        // Swap, then return through x5
        add(32'h40, jal(1),     1, 0, 32'h44, 0, 0, 0);
        add(32'h80, jalr(5, 1), 1, 1, 32'h84, 1, 1, 32'h44);
        add(32'h90, jalr(0, 5), 0, 1, 0,      1, 1, 32'h84);
        // Swap on empty stack pushes only
        add(32'hA0, jalr(5, 1), 1, 0, 32'hA4, 1, 0, 0);
        add(32'hB0, jalr(0, 1), 0, 1, 0,      1, 1, 32'hA4);
        // Non-stack instructions
        add(32'hC0, 32'h00000013,  0, 0, 0, 0, 0, 0);
        add(32'hC4, jalr(1, 0, 1), 0, 0, 0, 0, 0, 0);
        add(32'hC8, jal(0),        0, 0, 0, 0, 0, 0);
        add(32'hCC, jalr(0, 2),    0, 0, 0, 0, 0, 0);
        // JALR link variants
        add(32'hD0,  jalr(1, 1), 1, 0, 32'hD4, 0, 0, 0);
        add(32'hE0,  jalr(1, 5), 1, 1, 32'hE4, 1, 1, 32'hD4);
        add(32'hF0,  jalr(1, 2), 1, 0, 32'hF4, 0, 0, 0);
        add(32'h110, jalr(0, 5), 0, 1, 0,      1, 1, 32'hF4);
        add(32'h120, jalr(0, 1), 0, 1, 0,      1, 1, 32'hE4);
        // PC wrap
        add(32'hFFFFFFFC, jal(1),     1, 0, 32'h0, 0, 0, 0);
        add(32'h130,      jalr(0, 1), 0, 1, 0,     1, 1, 32'h0);
        // Swap on full stack pops only
        for (int k = 1; k <= 7; k++)
            add(32'(k * 32'h10), jal(5), 1, 0, 32'(k * 32'h10 + 4), 0, 0, 0);
        add(32'h500, jalr(5, 1), 0, 1, 0, 1, 1, 32'h74);
        add(32'h510, jalr(0, 5), 0, 1, 0, 1, 1, 32'h64);
        add(32'h520, jalr(0, 1), 0, 1, 0, 1, 1, 32'h54);
        add(32'h530, jalr(0, 1), 0, 1, 0, 1, 1, 32'h44);

        rst = 1'b1; inst_valid = 1'b0; inst_pc = '0; inst = '0; flush = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_inst_ready", {31'b0, inst_ready}, 32'd1);
        chk("reset_push", {31'b0, stk_push}, 32'd0);
        chk("reset_pop", {31'b0, stk_pop}, 32'd0);
        chk("reset_pred_valid", {31'b0, pred_valid}, 32'd0);
        chk("reset_pred_hit", {31'b0, pred_hit}, 32'd0);
        chk("reset_pred_target", pred_target, 32'd0);

        // Back-to-back table, one instruction per cycle
        foreach (vecs[i]) begin
            step();
            v = vecs[i];
            drive(v);
        end
        step();
        inst_valid = 1'b0;
        repeat (3) step();
        chk("table_leaves_3_entries", 32'(cnt), 32'd3);

        // Flush with a RET in the stage register and 3 stack entries
        inst_valid = 1'b1; inst_pc = 32'h600; inst = jalr(0, 1);
        step();
        inst_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("flush_no_pop", {31'b0, stk_pop}, 32'd0);
        chk("flush_no_push", {31'b0, stk_push}, 32'd0);
        step();
        flush = 1'b0;
        inst_valid = 1'b1; inst_pc = 32'h4440; inst = jal(1);
        pops = 0;
        drained = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (inst_ready) begin
                inst_valid = 1'b0;
                drained = 1'b1;
                break;
            end
            chk("drain_no_pred", {31'b0, pred_valid}, 32'd0);
            chk("drain_no_push", {31'b0, stk_push}, 32'd0);
            if (stk_pop) pops++;
            @(posedge clk);
        end
        inst_valid = 1'b0;
        chk("drain_finished", {31'b0, drained}, 32'd1);
        chk("drain_pop_count", 32'(pops), 32'd3);
        chk("drain_stack_empty", 32'(cnt), 32'd0);
        step();
        @(negedge clk);
        chk("post_drain_no_push", {31'b0, stk_push}, 32'd0);
        chk("post_drain_stack", 32'(cnt), 32'd0);

        // Reset during DRAIN
        step();
        add(32'h600, jal(1), 1, 0, 32'h604, 0, 0, 0);
        v = vecs[vecs.size()-1];
        drive(v);
        step();
        add(32'h700, jal(1), 1, 0, 32'h704, 0, 0, 0);
        v = vecs[vecs.size()-1];
        drive(v);
        step();
        inst_valid = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("drain_first_pop", {31'b0, stk_pop}, 32'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_drain_no_pop", {31'b0, stk_pop}, 32'd0);
        chk("rst_drain_no_push", {31'b0, stk_push}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_ready", {31'b0, inst_ready}, 32'd1);
        chk("after_rst_pop", {31'b0, stk_pop}, 32'd0);
        chk("after_rst_push", {31'b0, stk_push}, 32'd0);
        chk("after_rst_pv", {31'b0, pred_valid}, 32'd0);

        // Reset while a RET is being decoded
        step();
        add(32'h800, jal(1), 1, 0, 32'h804, 0, 0, 0);
        v = vecs[vecs.size()-1];
        drive(v);
        step();
        inst_valid = 1'b1; inst_pc = 32'h900; inst = jalr(0, 1);
        step();
        inst_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ret_no_pop", {31'b0, stk_pop}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ret_no_pv", {31'b0, pred_valid}, 32'd0);
        chk("rst_ret_no_hit", {31'b0, pred_hit}, 32'd0);
        chk("rst_ret_target", pred_target, 32'd0);
        chk("rst_ret_ready", {31'b0, inst_ready}, 32'd1);
        chk("rst_ret_strobes", {30'b0, stk_push, stk_pop}, 32'd0);

        repeat (3) step();
        chk("stk_queue_drained", 32'(sq.size()), 32'd0);
        chk("pred_queue_drained", 32'(pq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
